// File: rtl/piso_reader.sv
// piso_reader: parallel-in/serial-out word reader, one word per load handshake,
// one bit per serial handshake, complementary s1/s2 output pair.
module piso_reader #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             s1,
    output logic             s2,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    state_d = SHIFT;
                    shreg_d = din;
                    cnt_d   = CW'(WIDTH - 1);
                end
            end
            SHIFT: begin
                if (bit_ready) begin
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        // move the next bit toward the output end, zero-filling behind it
                        shreg_d = MSB_FIRST ? shreg_q << 1 : shreg_q >> 1;
                        cnt_d   = cnt_q - 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_ready = state_q == IDLE;
        bit_valid  = state_q == SHIFT;
        busy       = state_q == SHIFT || state_q == DONE;
        done       = state_q == DONE;
        s1         = bit_valid && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
        s2         = ~s1;
    end
endmodule

// File: tb/tb_piso_reader.sv
// tb_piso_reader: scoreboard bench for piso_reader (8-bit MSB-first and 4-bit LSB-first).
module tb_piso_reader;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       lv8, lr8, bv8, br8, s1_8, s2_8, busy8, done8;
    logic [7:0] din8;
    logic       lv4, lr4, bv4, br4, s1_4, s2_4, busy4, done4;
    logic [3:0] din4;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt8 = 0;
    bit q8[$];
    bit q4[$];

    piso_reader #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
        .clk(clk), .reset(reset), .load_valid(lv8), .load_ready(lr8), .din(din8),
        .bit_valid(bv8), .bit_ready(br8), .s1(s1_8), .s2(s2_8), .busy(busy8), .done(done8)
    );

    piso_reader #(.WIDTH(4), .MSB_FIRST(1'b0)) dut4 (
        .clk(clk), .reset(reset), .load_valid(lv4), .load_ready(lr4), .din(din4),
        .bit_valid(bv4), .bit_ready(br4), .s1(s1_4), .s2(s2_4), .busy(busy4), .done(done4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push a word's bits on accepted load, pop on each bit transfer.
    always @(negedge clk) begin
        if (reset) begin
            if (lv8 && lr8) for (int i = 7; i >= 0; i--) q8.push_back(din8[i]);
            if (lv4 && lr4) for (int i = 0; i < 4; i++) q4.push_back(din4[i]);
            if (bv8) begin
                check("s2_compl8", s2_8, !s1_8);
                check("busy8", busy8, 1);
                if (q8.size() == 0) check("extra_bit8", bv8, 0);
                else if (br8) check("bit8", s1_8, q8.pop_front());
                else check("hold8", s1_8, q8[0]);
            end
            if (bv4) begin
                check("s2_compl4", s2_4, !s1_4);
                if (q4.size() == 0) check("extra_bit4", bv4, 0);
                else if (br4) check("bit4", s1_4, q4.pop_front());
                else check("hold4", s1_4, q4[0]);
            end
            if (done8) done_cnt8++;
        end
    end

    task automatic load_word8(input logic [7:0] d, input logic [63:0] bp, input int junk,
                              output int dc);
        int n;
        tick();
        lv8 = 1'b1;
        din8 = d;
        n = 0;
        @(negedge clk);
        while (!lr8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tick();
        lv8 = 1'b0;
        br8 = !bp[1];
        dc = 0;
        for (int c = 1; c < 40; c++) begin
            @(negedge clk);
            if (done8) begin
                dc = c;
                break;
            end
            tick();
            br8 = !bp[c+1];
            if (c + 1 == junk) begin
                lv8 = 1'b1;
                din8 = 8'hFF;
            end else if (c == junk) begin
                lv8 = 1'b0;
            end
        end
        if (dc == 0) check("done_timeout8", done8, 1);
        tick();
        br8 = 1'b1;
        lv8 = 1'b0;
        @(negedge clk);
        check("ready_after8", lr8, 1);
        check("done_single8", done8, 0);
    endtask

    initial begin
        int dc;
        int acc;
        lv8 = 0; br8 = 1; din8 = '0;
        lv4 = 0; br4 = 1; din4 = '0;
        #12;
        check("rst_ready", lr8, 1);
        check("rst_valid", bv8, 0);
        check("rst_s1", s1_8, 0);
        check("rst_s2", s2_8, 1);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_s2_4", s2_4, 1);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("idle_ready", lr8, 1);
        check("idle_s2", s2_8, 1);

        load_word8(8'hA5, 64'h0, 0, dc);
        check("a5_done_cyc", dc, 9);
        check("a5_q_empty", q8.size(), 0);

        load_word8(8'hF0, 64'h1C, 0, dc);
        check("bp_done_cyc", dc, 12);
        check("bp_q_empty", q8.size(), 0);

        load_word8(8'h81, 64'h0, 3, dc);
        check("busy_ld_done_cyc", dc, 9);
        check("busy_ld_q_empty", q8.size(), 0);
        tick();
        @(negedge clk);
        check("no_second_word", bv8, 0);

        tick();
        lv8 = 1'b1;
        din8 = 8'hC3;
        tick();
        lv8 = 1'b0;
        tick();
        tick();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_ready", lr8, 1);
        check("arst_valid", bv8, 0);
        check("arst_s1", s1_8, 0);
        check("arst_s2", s2_8, 1);
        check("arst_busy", busy8, 0);
        check("arst_done", done8, 0);
        q8.delete();
        tick();
        reset = 1'b1;
        load_word8(8'h3C, 64'h0, 0, dc);
        check("post_rst_done_cyc", dc, 9);
        check("post_rst_q_empty", q8.size(), 0);

        tick();
        lv4 = 1'b1;
        din4 = 4'b0110;
        tick();
        lv4 = 1'b0;
        dc = 0;
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            if (done4) begin
                dc = c;
                break;
            end
            tick();
        end
        check("lsb_done_cyc", dc, 5);
        check("lsb_q_empty", q4.size(), 0);

        done_cnt8 = 0;
        tick();
        lv8 = 1'b1;
        din8 = 8'h01;
        tick();
        din8 = 8'h80;
        acc = 0;
        for (int c = 1; c < 30; c++) begin
            @(negedge clk);
            if (lr8) begin
                acc = c;
                break;
            end
            tick();
        end
        check("b2b_accept_cyc", acc, 10);
        tick();
        lv8 = 1'b0;
        @(negedge clk);
        check("b2b_first_valid", bv8, 1);
        check("b2b_first_bit", s1_8, 1);
        repeat (15) tick();
        check("b2b_done_count", done_cnt8, 2);
        check("b2b_q_empty", q8.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
